// File: rtl/ramp_pwm.sv
// ramp_pwm: period-latched PWM from a 0..PERIOD duty value with period strobe; dead-time pair enabled by RAMP_PWM_DEADTIME_EN
module ramp_pwm #(
  parameter int PRESCALE = 4,
  parameter int PERIOD   = 100,
  parameter int DEAD     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] duty_in,
  output logic       pwm_out,
  output logic       pwm_n_out,
  output logic       period_strobe,
  output logic [6:0] duty_q
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  if (PRESCALE < 1 || PERIOD < 1 || PERIOD > 127 || DEAD < 1) begin : g_bad_param
    $error("ramp_pwm: illegal parameter set");
  end
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [6:0]    ph_q, ph_d, duty_d;
  logic          tick, wrap, raw, pwm_d;
  assign tick = enable && pre_cnt_q == PW'(PRESCALE - 1);
  assign wrap = tick && ph_q == 7'(PERIOD - 1);
  assign raw  = ph_q < duty_q;
  // next-state: prescaler, phase and the duty latch that only moves at the wrap
  always_comb begin
    pre_cnt_d = !enable ? pre_cnt_q : tick ? '0 : pre_cnt_q + 1'b1;
    ph_d      = !tick ? ph_q : wrap ? '0 : ph_q + 7'd1;
    duty_d    = !wrap ? duty_q : duty_in > 7'(PERIOD) ? 7'(PERIOD) : duty_in;
  end
  // counters, duty latch and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt_q     <= '0;
      ph_q          <= '0;
      duty_q        <= '0;
      pwm_out       <= 1'b0;
      period_strobe <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      ph_q          <= ph_d;
      duty_q        <= duty_d;
      pwm_out       <= pwm_d;
      period_strobe <= wrap;
    end
  end
`ifdef RAMP_PWM_DEADTIME_EN
  localparam int DW = $clog2(DEAD + 1);
  logic [DW-1:0] dead_q, dead_d;
  logic          raw_prev_q, pwm_n_d, settled;
  // dead counter restarts on every raw edge and saturates once the level has settled
  always_comb begin
    dead_d  = (!enable || raw != raw_prev_q) ? '0 : dead_q == DW'(DEAD) ? dead_q : dead_q + 1'b1;
    settled = dead_d == DW'(DEAD);
    pwm_d   = enable & raw & settled;
    pwm_n_d = enable & ~raw & settled;
  end
  // dead-time state and complementary output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dead_q     <= '0;
      raw_prev_q <= 1'b0;
      pwm_n_out  <= 1'b0;
    end else begin
      dead_q     <= dead_d;
      raw_prev_q <= raw;
      pwm_n_out  <= pwm_n_d;
    end
  end
`else
  assign pwm_d     = enable & raw;
  assign pwm_n_out = 1'b0;
`endif
endmodule

// File: tb/tb_ramp_pwm.sv
// tb_ramp_pwm: scoreboard bench for ramp_pwm against a position-in-period reference model
module tb_ramp_pwm;
  localparam int PS  = 4;
  localparam int PER = 100;
  localparam int DT  = 2;
  localparam int T   = PS * PER;
  typedef struct packed {
    logic       p;
    logic       pn;
    logic       s;
    logic [6:0] d;
  } exp_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] duty_in = '0;
  logic       pwm_out, pwm_n_out, period_strobe;
  logic [6:0] duty_q;
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         checking = 0;
  int         n = 0;
  int         dq = 0;
`ifdef RAMP_PWM_DEADTIME_EN
  logic       rawp = 1'b0;
  int         dc = 0;
`endif
  ramp_pwm #(.PRESCALE(PS), .PERIOD(PER), .DEAD(DT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .duty_in(duty_in),
    .pwm_out(pwm_out), .pwm_n_out(pwm_n_out), .period_strobe(period_strobe), .duty_q(duty_q)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // one clock of stimulus; the model works from the position within the period
  task automatic step(input logic en, input logic [6:0] d, input logic r);
    exp_t e;
    logic rw;
    @(negedge clock);
    enable = en;
    duty_in = d;
    reset = r;
    e = '0;
    if (r) begin
      n = 0;
      dq = 0;
`ifdef RAMP_PWM_DEADTIME_EN
      rawp = 1'b0;
      dc = 0;
`endif
    end else begin
      rw = (n / PS) < dq;
      if (en) begin
        n++;
        if (n == T) begin
          n = 0;
          dq = int'(d) > PER ? PER : int'(d);
          e.s = 1'b1;
        end
      end
      e.d = 7'(dq);
`ifdef RAMP_PWM_DEADTIME_EN
      dc = (!en || rw != rawp) ? 0 : (dc == DT ? DT : dc + 1);
      rawp = rw;
      e.p = en && rw && dc == DT;
      e.pn = en && !rw && dc == DT;
`else
      e.p = en && rw;
`endif
    end
    sb.push_back(e);
    checking = 1;
  endtask
  task automatic run(input int len, input logic [6:0] d);
    for (int i = 0; i < len; i++) step(1'b1, d, 1'b0);
  endtask
  task automatic align(input int pos, input logic [6:0] d);
    while (n != pos) step(1'b1, d, 1'b0);
  endtask
  task automatic async_reset();
    @(posedge clock);
    #2;
    chk("duty_before_reset", duty_q, 40);
    #1;
    reset = 1'b1;
    #1;
    chk("async_pwm", pwm_out, 0);
    chk("async_pwm_n", pwm_n_out, 0);
    chk("async_strobe", period_strobe, 0);
    chk("async_duty", duty_q, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 7'd40, 1'b1);
  endtask
  // monitor: every clock the DUT presents a new output set; pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (checking) begin
        if (sb.size() == 0) chk("sb_underflow", 0, 1);
        else begin
          e = sb.pop_front();
          chk("pwm_out", pwm_out, e.p);
          chk("pwm_n_out", pwm_n_out, e.pn);
          chk("period_strobe", period_strobe, e.s);
          chk("duty_q", duty_q, e.d);
        end
      end
    end
  end
  initial begin
    logic [6:0] d;
    #1;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pwm_n", pwm_n_out, 0);
    chk("rst_strobe", period_strobe, 0);
    chk("rst_duty", duty_q, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 7'd0, 1'b1);
    run(950, 7'd40);
    async_reset();
    run(1200, 7'd25);
    align(50, 7'd25);
    align(0, 7'd50);
    run(400, 7'd50);
    run(800, 7'd0);
    run(800, 7'd100);
    run(800, 7'd127);
    align(0, 7'd25);
    align(40, 7'd25);
    for (int i = 0; i < 37; i++) step(1'b0, 7'd25, 1'b0);
    align(0, 7'd25);
    run(400, 7'd25);
    for (int k = 0; k < 25; k++) begin
      d = 7'($urandom_range(0, 127));
      for (int i = 0, len = $urandom_range(1, 500); i < len; i++) begin
        if ($urandom_range(0, 99) == 0) d = 7'($urandom_range(0, 127));
        step(1'b1, d, 1'b0);
      end
      if ($urandom_range(0, 3) == 0)
        for (int i = 0, len = $urandom_range(1, 40); i < len; i++) step(1'b0, d, 1'b0);
      if (k == 12) step(1'b1, d, 1'b1);
    end
    @(posedge clock);
    #2;
    checking = 0;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
